// File: rtl/isa_pkg.sv
// MIPS opcode constants, instruction field slices and issue FSM encoding.
// Shared by the instruction issue front end and DatapathController.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_MUL      = 6'b011100;
    localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MUL_HOLD = 2'd2
    } issueState_t;

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: storage, read/write pointers and occupancy.
// Flush clears pointers and count but leaves storage untouched.
module issue_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Push,
    input  logic                     Pop,
    input  logic                     Flush,
    input  logic [DATA_W-1:0]        WrData,
    output logic [DATA_W-1:0]        Head,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic              doPush;
    logic              doPop;

    assign Empty  = (count == '0);
    assign Full   = (count == CW'(DEPTH));
    assign doPush = Push && !Full;
    assign doPop  = Pop && !Empty;
    assign Head   = mem[rdPtr];
    assign Count  = count;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= WrData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Opcode producer for DatapathController: buffers instruction words and
// issues decoded fields, stalling one cycle after every multiply.
module instr_issue_queue
    import isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [DATA_W-1:0]      InstrIn,
    input  logic                   InstrValid,
    output logic                   InstrReady,
    input  logic                   Flush,
    output logic                   IssueValid,
    input  logic                   IssueReady,
    output logic [5:0]             OpCode,
    output logic [4:0]             Rs,
    output logic [4:0]             Rt,
    output logic [4:0]             Rd,
    output logic [5:0]             Funct,
    output logic [15:0]            Imm,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Empty,
    output logic                   Full
);

    localparam int CW = $clog2(DEPTH) + 1;

    issueState_t       state;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    assign InstrReady = !Full;
    assign IssueValid = (state == ISSUE);
    assign push       = InstrValid && !Full && !Flush;
    assign pop        = IssueValid && IssueReady;

    issue_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) uFifo (
        .Clk    (Clk),
        .Rst    (Rst),
        .Push   (push),
        .Pop    (pop),
        .Flush  (Flush),
        .WrData (InstrIn),
        .Head   (head),
        .Count  (Count),
        .Empty  (Empty),
        .Full   (Full)
    );

    assign OpCode = head[OPCODE_HI:OPCODE_LO];
    assign Rs     = head[RS_HI:RS_LO];
    assign Rt     = head[RT_HI:RT_LO];
    assign Rd     = head[RD_HI:RD_LO];
    assign Funct  = head[FUNCT_HI:FUNCT_LO];
    assign Imm    = head[IMM_HI:IMM_LO];

    // Transitions look at the post-edge occupancy so a push is visible next cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else if (Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= ISSUE;
                end
                ISSUE: begin
                    if (pop) begin
                        if (OpCode == OP_MUL) begin
                            state <= MUL_HOLD;
                        end else if (Count == CW'(1) && !push) begin
                            state <= IDLE;
                        end
                    end
                end
                MUL_HOLD: begin
                    if (Count != '0 || push) state <= ISSUE;
                    else                     state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
